// File: rtl/physics_pkg.sv
// physics_pkg: shared types and helpers for the wheel physics stages.
// Used by centre-of-mass, springs, ideal-shape and collision blocks.
package physics_pkg;

  localparam int POS_W     = 8;
  localparam int NODES_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    DONE
  } com_state_t;

  // Sign-extend the low w bits of v to a full 32-bit signed value.
  function automatic logic signed [31:0] sext_pos(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] sh;
    sh = v << (32 - w);
    return $signed(sh) >>> (32 - w);
  endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle.
// start loads the operands; done pulses when the quotient is final.
module serial_divider #(
  parameter int WIDTH = 12
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Shift in the next dividend bit and try subtracting the divisor.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
      if (!diff[WIDTH]) begin
        rem_d = diff;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/center_of_mass.sv
// center_of_mass: mean of all wheel node positions for the update stage.
// Snapshot, serial accumulate, then signed divide by the node count.
module center_of_mass
  import physics_pkg::*;
#(
  parameter int NUM_NODES     = NODES_DEF,
  parameter int POSITION_SIZE = POS_W
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            input_valid,
  input  logic signed [POSITION_SIZE-1:0] nodes [1:0][NUM_NODES],
  output logic signed [POSITION_SIZE-1:0] com_x,
  output logic signed [POSITION_SIZE-1:0] com_y,
  output logic                            busy,
  output logic                            output_valid
);

  localparam int SUM_W = POSITION_SIZE + $clog2(NUM_NODES + 1);
  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NODES - 1);
  localparam logic [SUM_W-1:0] DIVISOR = SUM_W'(NUM_NODES);

  typedef logic signed [POSITION_SIZE-1:0] pos_t;
  typedef logic signed [SUM_W-1:0]         sum_t;

  com_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  sum_t           sum_x_q, sum_x_d;
  sum_t           sum_y_q, sum_y_d;
  logic           neg_x_q, neg_x_d;
  logic           neg_y_q, neg_y_d;
  pos_t           com_x_q, com_x_d;
  pos_t           com_y_q, com_y_d;
  logic           ov_q, ov_d;
  pos_t           snap_x_q [NUM_NODES];
  pos_t           snap_x_d [NUM_NODES];
  pos_t           snap_y_q [NUM_NODES];
  pos_t           snap_y_d [NUM_NODES];

  logic             div_start;
  logic [SUM_W-1:0] mag_x, mag_y;
  logic [SUM_W-1:0] quo_x, quo_y;
  logic             done_x, done_y;

  // Next-state, accumulation and result registration.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_x_d   = sum_x_q;
    sum_y_d   = sum_y_q;
    neg_x_d   = neg_x_q;
    neg_y_d   = neg_y_q;
    com_x_d   = com_x_q;
    com_y_d   = com_y_q;
    ov_d      = 1'b0;
    snap_x_d  = snap_x_q;
    snap_y_d  = snap_y_q;
    div_start = 1'b0;
    mag_x     = '0;
    mag_y     = '0;
    unique case (state_q)
      IDLE: begin
        if (input_valid) begin
          snap_x_d = nodes[0];
          snap_y_d = nodes[1];
          sum_x_d  = '0;
          sum_y_d  = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        sum_x_d = sum_x_q + SUM_W'(sext_pos(
          32'(snap_x_q[idx_q]), POSITION_SIZE));
        sum_y_d = sum_y_q + SUM_W'(sext_pos(
          32'(snap_y_q[idx_q]), POSITION_SIZE));
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          neg_x_d   = sum_x_d[SUM_W-1];
          neg_y_d   = sum_y_d[SUM_W-1];
          mag_x     = neg_x_d ? -sum_x_d : sum_x_d;
          mag_y     = neg_y_d ? -sum_y_d : sum_y_d;
          div_start = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        if (done_x && done_y) begin
          com_x_d = POSITION_SIZE'(neg_x_q ? -quo_x : quo_x);
          com_y_d = POSITION_SIZE'(neg_y_q ? -quo_y : quo_y);
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      neg_x_q  <= 1'b0;
      neg_y_q  <= 1'b0;
      com_x_q  <= '0;
      com_y_q  <= '0;
      ov_q     <= 1'b0;
      snap_x_q <= '{default: '0};
      snap_y_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
      neg_x_q  <= neg_x_d;
      neg_y_q  <= neg_y_d;
      com_x_q  <= com_x_d;
      com_y_q  <= com_y_d;
      ov_q     <= ov_d;
      snap_x_q <= snap_x_d;
      snap_y_q <= snap_y_d;
    end
  end

  serial_divider #(.WIDTH(SUM_W)) u_div_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (mag_x),
    .divisor  (DIVISOR),
    .quotient (quo_x),
    .done     (done_x)
  );

  serial_divider #(.WIDTH(SUM_W)) u_div_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (mag_y),
    .divisor  (DIVISOR),
    .quotient (quo_y),
    .done     (done_y)
  );

  assign com_x        = com_x_q;
  assign com_y        = com_y_q;
  assign busy         = (state_q != IDLE);
  assign output_valid = ov_q;

endmodule

// File: tb/tb_center_of_mass.sv
// tb_center_of_mass: vector table, random model and corner sequences.
// Covers a 10-node build and a single-node build side by side.
module tb_center_of_mass;

  localparam int N    = 10;
  localparam int P    = 8;
  localparam int SW   = P + $clog2(N + 1);
  localparam int LAT  = N + SW + 1;
  localparam int SW1  = P + $clog2(2);
  localparam int LAT1 = 1 + SW1 + 1;

  typedef struct {
    int x [N];
    int y [N];
    int ex;
    int ey;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv  = 1'b0;
  logic iv1 = 1'b0;
  logic signed [P-1:0] nodes  [1:0][N];
  logic signed [P-1:0] nodes1 [1:0][1];
  logic signed [P-1:0] cx, cy, cx1, cy1;
  logic busy, ov, busy1, ov1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  center_of_mass #(.NUM_NODES(N), .POSITION_SIZE(P)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .input_valid  (iv),
    .nodes        (nodes),
    .com_x        (cx),
    .com_y        (cy),
    .busy         (busy),
    .output_valid (ov)
  );

  center_of_mass #(.NUM_NODES(1), .POSITION_SIZE(P)) dut1 (
    .clk_in       (clk),
    .rst_in       (rst),
    .input_valid  (iv1),
    .nodes        (nodes1),
    .com_x        (cx1),
    .com_y        (cy1),
    .busy         (busy1),
    .output_valid (ov1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for output_valid of the selected instance, bounded.
  task automatic wait_ov(input bit sel, input int bound,
                         output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if ((sel ? ov1 : ov) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic int mean(input int a [N]);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += a[i];
    return s / N;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) begin
      nodes[0][i] = P'(v.x[i]);
      nodes[1][i] = P'(v.y[i]);
    end
  endtask

  vec_t tbl [$];
  vec_t v;
  int   lat;
  int   pulses;
  int   px, py;

  initial begin
    for (int i = 0; i < N; i++) begin
      nodes[0][i] = '0;
      nodes[1][i] = '0;
    end
    nodes1[0][0] = '0;
    nodes1[1][0] = '0;

    // directed vectors with hand-computed results
    for (int i = 0; i < N; i++) begin v.x[i] = 5; v.y[i] = -3; end
    v.ex = 5; v.ey = -3; tbl.push_back(v);
    for (int i = 0; i < N; i++) begin v.x[i] = i; v.y[i] = -i; end
    v.ex = 4; v.ey = -4; tbl.push_back(v);
    for (int i = 0; i < N; i++) begin v.x[i] = -128; v.y[i] = 127; end
    v.ex = -128; v.ey = 127; tbl.push_back(v);
    for (int i = 0; i < N; i++) begin
      v.x[i] = (i % 2 == 0) ? 127 : -128;
      v.y[i] = -1;
    end
    v.ex = 0; v.ey = -1; tbl.push_back(v);
    for (int i = 0; i < N; i++) begin
      v.x[i] = (i == 0) ? -7 : 0;
      v.y[i] = (i < 7) ? 9 : 0;
    end
    v.ex = 0; v.ey = 6; tbl.push_back(v);
    // random vectors against the arithmetic model
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        v.x[i] = int'($urandom_range(0, 255)) - 128;
        v.y[i] = int'($urandom_range(0, 255)) - 128;
      end
      v.ex = mean(v.x);
      v.ey = mean(v.y);
      tbl.push_back(v);
    end

    // reset state
    repeat (3) tick();
    chk("rst_com_x", int'(cx), 0);
    chk("rst_com_y", int'(cy), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ov", int'(ov), 0);
    chk("rst_busy1", int'(busy1), 0);
    rst = 1'b0;
    tick();

    // table: each request issued in the first IDLE cycle after the last
    foreach (tbl[k]) begin
      load(tbl[k]);
      iv = 1'b1;
      tick();
      iv = 1'b0;
      chk($sformatf("v%0d_busy", k), int'(busy), 1);
      wait_ov(1'b0, LAT + 10, lat);
      chk($sformatf("v%0d_lat", k), lat, LAT);
      chk($sformatf("v%0d_x", k), int'(cx), tbl[k].ex);
      chk($sformatf("v%0d_y", k), int'(cy), tbl[k].ey);
      tick();
      chk($sformatf("v%0d_pulse", k), int'(ov), 0);
      chk($sformatf("v%0d_idle", k), int'(busy), 0);
    end

    // snapshot isolation and request-while-busy
    for (int i = 0; i < N; i++) begin
      nodes[0][i] = P'(3 * i);
      nodes[1][i] = -8'sd9;
    end
    iv = 1'b1;
    tick();
    iv = 1'b0;
    for (int i = 0; i < N; i++) begin
      nodes[0][i] = '0;
      nodes[1][i] = '0;
    end
    tick();
    tick();
    iv = 1'b1;
    tick();
    iv = 1'b0;
    pulses = 0;
    px = 0;
    py = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (ov === 1'b1) begin
        pulses++;
        px = int'(cx);
        py = int'(cy);
      end
    end
    chk("snap_pulses", pulses, 1);
    chk("snap_x", px, 13);
    chk("snap_y", py, -9);
    chk("snap_idle", int'(busy), 0);

    // request in the DONE cycle is dropped
    for (int i = 0; i < N; i++) begin
      nodes[0][i] = 8'sd1;
      nodes[1][i] = 8'sd2;
    end
    iv = 1'b1;
    tick();
    iv = 1'b0;
    wait_ov(1'b0, LAT + 10, lat);
    chk("done_lat", lat, LAT);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    chk("done_req_drop", int'(busy), 0);

    // reset during DIVIDE aborts the computation
    for (int i = 0; i < N; i++) begin
      nodes[0][i] = 8'sd20;
      nodes[1][i] = -8'sd20;
    end
    iv = 1'b1;
    tick();
    iv = 1'b0;
    repeat (N + 4) tick();
    rst = 1'b1;
    tick();
    chk("abort_x", int'(cx), 0);
    chk("abort_y", int'(cy), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ov", int'(ov), 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (ov === 1'b1) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    rst = 1'b1;
    iv  = 1'b1;
    tick();
    rst = 1'b0;
    iv  = 1'b0;
    chk("rst_over_req", int'(busy), 0);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    wait_ov(1'b0, LAT + 10, lat);
    chk("fresh_lat", lat, LAT);
    chk("fresh_x", int'(cx), 20);
    chk("fresh_y", int'(cy), -20);
    tick();

    // single-node build, back-to-back requests
    nodes1[0][0] = -8'sd7;
    nodes1[1][0] = 8'sd6;
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    wait_ov(1'b1, LAT1 + 10, lat);
    chk("n1_lat", lat, LAT1);
    chk("n1_x", int'(cx1), -7);
    chk("n1_y", int'(cy1), 6);
    tick();
    nodes1[0][0] = 8'sd100;
    nodes1[1][0] = -8'sd128;
    iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    wait_ov(1'b1, LAT1 + 10, lat);
    chk("n1_b2b_lat", lat, LAT1);
    chk("n1_b2b_x", int'(cx1), 100);
    chk("n1_b2b_y", int'(cy1), -128);
    tick();
    for (int k = 0; k < 4; k++) begin
      px = int'($urandom_range(0, 255)) - 128;
      py = int'($urandom_range(0, 255)) - 128;
      nodes1[0][0] = P'(px);
      nodes1[1][0] = P'(py);
      iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      wait_ov(1'b1, LAT1 + 10, lat);
      chk($sformatf("n1r%0d_x", k), int'(cx1), px);
      chk($sformatf("n1r%0d_y", k), int'(cy1), py);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
